// File: rtl/gate_chk_pkg.sv
// Shared definitions for the two-input gate response checker.
//   state_e : checker FSM states
//   TT_*    : truth tables for the two-input gate family, indexed by {a,b}
//             (bit 3 = a=1,b=1 ... bit 0 = a=0,b=0)
package gate_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_checker.sv
// Response monitor for a two-input gate under test. Captures each applied
// {a,b} vector, waits SETTLE_CYCLES, samples y and compares it against a
// truth table latched at start. Accumulates error count, vector count,
// coverage and first-failure information; reports pass when the run is done.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start_i               begin a run (honoured in IDLE and DONE only)
//   truth_table_i [3:0]   expected y indexed by {a,b}, latched on start
//   vec_valid_i           a_i/b_i carry a newly applied vector
//   a_i, b_i              vector applied to the gate
//   y_i                   gate output under test
//   busy_o                run in progress (ARMED, SETTLE, CHECK)
//   done_o                run complete (level)
//   pass_o                done with zero errors
//   err_count_o           saturating mismatch count
//   vec_count_o           vectors checked this run (wraps)
//   cov_o [3:0]           sticky bitmap of {a,b} combinations checked
//   first_fail_valid_o    a mismatch occurred this run
//   first_fail_vec_o      {a,b} of the first mismatch
module gate_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_VECTORS   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       truth_table_i,
    input  logic             vec_valid_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] vec_count_o,
    output logic [3:0]       cov_o,
    output logic             first_fail_valid_o,
    output logic [1:0]       first_fail_vec_o
);

    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
    localparam logic [7:0]    NUM_VEC     = 8'(NUM_VECTORS);

    state_e           state_q, state_d;
    logic [3:0]       tt_q, tt_d;
    logic [1:0]       vec_q, vec_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    // Run-length counter kept separate from vec_count so that a narrow,
    // wrapping vec_count still terminates the run at NUM_VECTORS.
    logic [7:0]       run_q, run_d;
    logic [3:0]       cov_q, cov_d;
    logic             ffv_q, ffv_d;
    logic [1:0]       ffvec_q, ffvec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mismatch;

    assign mismatch = (y_i != tt_q[vec_q]);

    always_comb begin
        state_d  = state_q;
        tt_d     = tt_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        vcnt_d   = vcnt_q;
        run_d    = run_q;
        cov_d    = cov_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // start wins over a simultaneous vec_valid: no capture here.
                if (start_i) begin
                    tt_d    = truth_table_i;
                    err_d   = '0;
                    vcnt_d  = '0;
                    run_d   = '0;
                    cov_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vec_valid_i) begin
                    vec_d = {a_i, b_i};
                    if (SETTLE_CYCLES > 0) begin
                        settle_d = SETTLE_LOAD;
                        state_d  = ST_SETTLE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q - SW'(1);
                if (settle_q <= SW'(1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != {CNT_W{1'b1}}) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
                cov_d[vec_q] = 1'b1;
                vcnt_d       = vcnt_q + CNT_W'(1);
                run_d        = run_q + 8'd1;
                state_d      = (run_d == NUM_VEC) ? ST_DONE : ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ARMED) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tt_q     <= '0;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            vcnt_q   <= '0;
            run_q    <= '0;
            cov_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tt_q     <= tt_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            vcnt_q   <= vcnt_d;
            run_q    <= run_d;
            cov_q    <= cov_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign pass_o             = done_q && (err_q == '0);
    assign err_count_o        = err_q;
    assign vec_count_o        = vcnt_q;
    assign cov_o              = cov_q;
    assign first_fail_valid_o = ffv_q;
    assign first_fail_vec_o   = ffvec_q;

endmodule
